regfile_wb_arbiter: RTL and testbench

- Write-side front end for the processor register file. It is the only driver of the regfile write port.
- Merges two result sources onto the single write port:
  - the in-order pipeline writeback, which has priority and no backpressure;
  - a long-latency unit (mul/div/load-miss) with a valid/ready handshake.
- Buffers long-latency results in a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall on pending long-latency destinations.

---
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority, long-latency
// results queue in a small FIFO, and a busy scoreboard stalls decode on pending destinations.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_BITS  = $clog2(REG_COUNT),
  parameter int unsigned DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       pipe_wen,
  input  logic [REG_BITS-1:0]        pipe_rd,
  input  logic signed [WIDTH-1:0]    pipe_data,
  input  logic                       mc_issue,
  input  logic [REG_BITS-1:0]        mc_issue_rd,
  input  logic                       mc_valid,
  input  logic [REG_BITS-1:0]        mc_rd,
  input  logic signed [WIDTH-1:0]    mc_data,
  output logic                       mc_ready,
  input  logic [REG_BITS-1:0]        dec_rs1,
  input  logic [REG_BITS-1:0]        dec_rs2,
  input  logic [REG_BITS-1:0]        dec_rd,
  output logic                       stall,
  output logic                       write_en,
  output logic [REG_BITS-1:0]        write_reg,
  output logic signed [WIDTH-1:0]    write_data
);

  localparam int unsigned PtrBits = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntBits = $clog2(DEPTH) + 1;

  logic [REG_BITS-1:0]     fifo_rd_q   [DEPTH];
  logic signed [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [PtrBits-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrBits-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntBits-1:0]      count_q, count_d;

  logic                    write_en_q, write_en_d;
  logic [REG_BITS-1:0]     write_reg_q, write_reg_d;
  logic signed [WIDTH-1:0] write_data_q, write_data_d;
  logic                    fifo_wr_q, fifo_wr_d;
  logic [REG_COUNT-1:0]    busy_q, busy_d;

  logic                    full, empty, push, pop, pipe_sel;
  logic [REG_BITS-1:0]     head_rd;
  logic signed [WIDTH-1:0] head_data;

  assign full      = (count_q == CntBits'(DEPTH));
  assign empty     = (count_q == '0);
  assign mc_ready  = ~full;
  assign push      = mc_valid & ~full;
  assign pipe_sel  = pipe_wen & (pipe_rd != '0);
  assign pop       = ~pipe_sel & ~empty;
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrBits'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrBits'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntBits'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntBits'(1);
    end
  end

  // Unselected cycles hold write_reg/write_data; a head with rd==0 drains silently.
  always_comb begin
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    fifo_wr_d    = 1'b0;
    if (pipe_sel) begin
      write_en_d   = 1'b1;
      write_reg_d  = pipe_rd;
      write_data_d = pipe_data;
    end else if (pop && (head_rd != '0)) begin
      write_en_d   = 1'b1;
      write_reg_d  = head_rd;
      write_data_d = head_data;
      fifo_wr_d    = 1'b1;
    end
  end

  // Busy clears one edge after the FIFO write is driven, so stall covers the commit cycle.
  always_comb begin
    busy_d = busy_q;
    if (fifo_wr_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (mc_issue && (mc_issue_rd != '0)) begin
      busy_d[mc_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      fifo_wr_q    <= 1'b0;
      busy_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      fifo_wr_q    <= fifo_wr_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mc_rd;
      fifo_data_q[wr_ptr_q] <= mc_data;
    end
  end

  assign write_en   = write_en_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign stall      = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_BITS = 5;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    pipe_wen;
  logic [REG_BITS-1:0]     pipe_rd;
  logic signed [WIDTH-1:0] pipe_data;
  logic                    mc_issue;
  logic [REG_BITS-1:0]     mc_issue_rd;
  logic                    mc_valid;
  logic [REG_BITS-1:0]     mc_rd;
  logic signed [WIDTH-1:0] mc_data;
  logic                    mc_ready;
  logic [REG_BITS-1:0]     dec_rs1, dec_rs2, dec_rd;
  logic                    stall;
  logic                    write_en;
  logic [REG_BITS-1:0]     write_reg;
  logic signed [WIDTH-1:0] write_data;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .pipe_wen    (pipe_wen),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .mc_issue    (mc_issue),
    .mc_issue_rd (mc_issue_rd),
    .mc_valid    (mc_valid),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .mc_ready    (mc_ready),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .stall       (stall),
    .write_en    (write_en),
    .write_reg   (write_reg),
    .write_data  (write_data)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [REG_BITS-1:0] rd,
                          input logic [WIDTH-1:0] data);
    check({tag, ".en"}, WIDTH'(write_en), WIDTH'(en));
    check({tag, ".reg"}, WIDTH'(write_reg), WIDTH'(rd));
    check({tag, ".data"}, write_data, data);
  endtask

  logic [REG_BITS-1:0] fill_rd [6];

  initial begin
    rstn = 1'b0;
    pipe_wen = 1'b0; pipe_rd = '0; pipe_data = '0;
    mc_issue = 1'b0; mc_issue_rd = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
    dec_rs1 = 5'd7; dec_rs2 = '0; dec_rd = '0;
    fill_rd[0] = 5'd1; fill_rd[1] = 5'd2; fill_rd[2] = 5'd3;
    fill_rd[3] = 5'd4; fill_rd[4] = 5'd5; fill_rd[5] = 5'd6;

    // Reset state
    step(); step();
    check_wr("reset", 1'b0, 5'd0, 32'h0);
    check("reset.mc_ready", WIDTH'(mc_ready), 32'd1);
    check("reset.stall", WIDTH'(stall), 32'd0);
    rstn = 1'b1;
    dec_rs1 = '0;

    // Pipeline write, then pipe_rd=0 is ignored and outputs hold
    pipe_wen = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    step();
    check_wr("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
    pipe_rd = 5'd0; pipe_data = 32'h12345678;
    step();
    check_wr("pipe0", 1'b0, 5'd5, 32'hDEADBEEF);
    pipe_wen = 1'b0;

    // Long-latency op to x9 with scoreboard stall
    mc_issue = 1'b1; mc_issue_rd = 5'd9;
    step();
    mc_issue = 1'b0; dec_rs2 = 5'd9;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_data = -32'sd3;
    #1;
    check("mc9.stall_pre", WIDTH'(stall), 32'd1);
    step();
    mc_valid = 1'b0;
    check("mc9.hs_no_write", WIDTH'(write_en), 32'd0);
    check("mc9.stall_hs", WIDTH'(stall), 32'd1);
    step();
    check_wr("mc9.write", 1'b1, 5'd9, 32'hFFFFFFFD);
    check("mc9.stall_wr", WIDTH'(stall), 32'd1);
    step();
    check("mc9.stall_clr", WIDTH'(stall), 32'd0);
    check("mc9.idle", WIDTH'(write_en), 32'd0);
    dec_rs2 = '0;

    // Pipeline priority fills the FIFO, then drains in order
    pipe_wen = 1'b1; pipe_rd = fill_rd[0]; pipe_data = 32'h100;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA;
    step();
    check_wr("fill.p1", 1'b1, 5'd1, 32'h100);
    check("fill.ready1", WIDTH'(mc_ready), 32'd1);
    pipe_rd = fill_rd[1]; pipe_data = 32'h101;
    mc_rd = 5'd11; mc_data = 32'hB;
    step();
    check_wr("fill.p2", 1'b1, 5'd2, 32'h101);
    check("fill.ready2", WIDTH'(mc_ready), 32'd0);
    mc_rd = 5'd12; mc_data = 32'hC;
    for (int i = 2; i < 6; i++) begin
      pipe_rd = fill_rd[i]; pipe_data = 32'h100 + i;
      step();
      check("fill.ready_full", WIDTH'(mc_ready), 32'd0);
    end
    check_wr("fill.p6", 1'b1, 5'd6, 32'h105);
    pipe_wen = 1'b0;
    step();
    check_wr("drain.x10", 1'b1, 5'd10, 32'hA);
    check("drain.ready", WIDTH'(mc_ready), 32'd1);
    step();
    mc_valid = 1'b0;
    check_wr("drain.x11", 1'b1, 5'd11, 32'hB);
    step();
    check_wr("drain.x12", 1'b1, 5'd12, 32'hC);
    step();
    check("drain.empty", WIDTH'(write_en), 32'd0);

    // rd=0 result pops silently; issue to x0 never stalls
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h55;
    mc_issue = 1'b1; mc_issue_rd = 5'd0;
    step();
    mc_valid = 1'b0; mc_issue = 1'b0;
    check("x0.stall", WIDTH'(stall), 32'd0);
    step();
    check_wr("x0.pop", 1'b0, 5'd12, 32'hC);
    check("x0.ready", WIDTH'(mc_ready), 32'd1);

    // Set wins over clear on x4
    dec_rd = 5'd4;
    mc_issue = 1'b1; mc_issue_rd = 5'd4;
    step();
    mc_issue = 1'b0;
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h44;
    step();
    mc_valid = 1'b0;
    step();
    check_wr("x4.write", 1'b1, 5'd4, 32'h44);
    mc_issue = 1'b1; mc_issue_rd = 5'd4;
    step();
    mc_issue = 1'b0;
    check("x4.set_wins", WIDTH'(stall), 32'd1);
    step();
    check("x4.still_busy", WIDTH'(stall), 32'd1);
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h45;
    step();
    mc_valid = 1'b0;
    step();
    check_wr("x4.write2", 1'b1, 5'd4, 32'h45);
    step();
    check("x4.cleared", WIDTH'(stall), 32'd0);
    dec_rd = '0;

    // Reset mid-stream with one FIFO entry and busy[7]
    pipe_wen = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    mc_issue = 1'b1; mc_issue_rd = 5'd7;
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h77;
    step();
    mc_issue = 1'b0; mc_valid = 1'b0;
    dec_rs1 = 5'd7;
    #1;
    check("rst_mid.pre_stall", WIDTH'(stall), 32'd1);
    check("rst_mid.pre_en", WIDTH'(write_en), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check_wr("rst_mid", 1'b0, 5'd0, 32'h0);
    check("rst_mid.ready", WIDTH'(mc_ready), 32'd1);
    check("rst_mid.stall", WIDTH'(stall), 32'd0);
    pipe_wen = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid.no_x7", WIDTH'(write_en), 32'd0);
      check("rst_mid.stall_after", WIDTH'(stall), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
